// File: rtl/vcop_pkg.sv
// rtl/vcop_pkg.sv - shared types, op bit positions and width helper for the vector coprocessor sequencer
package vcop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        TAIL = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam int OP_VXOR     = 0;
    localparam int OP_VMACC    = 1;
    localparam int OP_VREDSUM  = 2;
    localparam int OP_VSLIDEUP = 3;
    localparam int OP_VRGATHER = 4;
    localparam int NOPS        = 5;

    // clog2 that never returns zero, so one-value counters still get a real bit
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vcop_beat_cnt.sv
// rtl/vcop_beat_cnt.sv - loadable up/down counter with terminal-count flag
module vcop_beat_cnt #(
    parameter int W    = 2,
    parameter bit UP   = 1'b1,
    parameter int TERM = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= UP ? cnt + 1'b1 : cnt - 1'b1;
        end
    end

    assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/vcop_seq_ctrl.sv
// rtl/vcop_seq_ctrl.sv - vector op sequencer: EXEC beats, drain tail, write-back handshake
// Optional performance counters enabled by defining VCOP_PERF_CNT_EN.
module vcop_seq_ctrl
    import vcop_pkg::*;
#(
    parameter int  VLEN     = 128,
    parameter int  DP_W     = 32,
    parameter int  MACC_LAT = 2,
    parameter int  RED_LAT  = 2,
    localparam int NBEATS   = VLEN / DP_W,
    localparam int BEAT_W   = clog2_safe(NBEATS),
    localparam int TAIL_W   = clog2_safe(((MACC_LAT > RED_LAT) ? MACC_LAT : RED_LAT) + 1)
) (
    input  logic              vsi_clk,
    input  logic              vsi_rst_n,
    input  logic              vsi_op_valid,
    output logic              vsi_op_ready,
    output logic              vsi_cop_idle,
    input  logic              is_vxor,
    input  logic              is_vmacc,
    input  logic              is_vredsum,
    input  logic              is_vslideup,
    input  logic              is_vrgather,
    output logic [NOPS-1:0]   op_onehot,
    output logic              exec_en,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              beat_first,
    output logic              beat_last,
    output logic              tail_en,
    output logic              wb_en,
    input  logic              wb_ack,
`ifdef VCOP_PERF_CNT_EN
    input  logic              perf_clr,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_retired,
`endif
    output logic              illegal_op
);

    state_t            state;
    logic [NOPS-1:0]   op_flags;
    logic              accept;
    logic              legal;
    logic              beat_tc;
    logic              tail_tc;
    logic [TAIL_W-1:0] tail_cnt;
    logic [TAIL_W-1:0] tail_lat;
    logic              macc_tail;
    logic              red_tail;

    assign op_flags = {is_vrgather, is_vslideup, is_vredsum, is_vmacc, is_vxor};
    assign accept   = vsi_op_valid && (state == IDLE);
    assign legal    = $onehot(op_flags);

    assign macc_tail = op_onehot[OP_VMACC] && (MACC_LAT > 0);
    assign red_tail  = op_onehot[OP_VREDSUM] && (RED_LAT > 0);
    assign tail_lat  = op_onehot[OP_VMACC] ? TAIL_W'(MACC_LAT) : TAIL_W'(RED_LAT);

    // Beat counter parks on the last beat so beat_idx holds in IDLE afterwards
    vcop_beat_cnt #(.W(BEAT_W), .UP(1'b1), .TERM(NBEATS - 1)) u_beat_cnt (
        .clk      (vsi_clk),
        .rst_n    (vsi_rst_n),
        .load     (accept && legal),
        .load_val ('0),
        .en       ((state == EXEC) && !beat_tc),
        .cnt      (beat_idx),
        .tc       (beat_tc)
    );

    vcop_beat_cnt #(.W(TAIL_W), .UP(1'b0), .TERM(1)) u_tail_cnt (
        .clk      (vsi_clk),
        .rst_n    (vsi_rst_n),
        .load     ((state == EXEC) && beat_tc),
        .load_val (tail_lat),
        .en       ((state == TAIL) && (tail_cnt != '0)),
        .cnt      (tail_cnt),
        .tc       (tail_tc)
    );

    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            state      <= IDLE;
            op_onehot  <= '0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            op_onehot <= op_flags;
                            state     <= EXEC;
                        end else begin
                            illegal_op <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (beat_tc) begin
                        state <= (macc_tail || red_tail) ? TAIL : WB;
                    end
                end
                TAIL: begin
                    if (tail_tc) begin
                        state <= WB;
                    end
                end
                WB: begin
                    if (wb_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign vsi_op_ready = (state == IDLE);
    assign vsi_cop_idle = (state == IDLE);
    assign exec_en      = (state == EXEC);
    assign tail_en      = (state == TAIL);
    assign wb_en        = (state == WB);
    assign beat_first   = exec_en && (beat_idx == '0);
    assign beat_last    = exec_en && beat_tc;

`ifdef VCOP_PERF_CNT_EN
    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            perf_busy_cyc <= '0;
            perf_retired  <= '0;
        end else if (perf_clr) begin
            perf_busy_cyc <= '0;
            perf_retired  <= '0;
        end else begin
            if (state != IDLE) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end
            if ((state == WB) && wb_ack) begin
                perf_retired <= perf_retired + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vcop_seq_ctrl.sv
// tb/tb_vcop_seq_ctrl.sv - randomized transaction-level check of vcop_seq_ctrl across three parameter sets
module tb_vcop_seq_ctrl;

    logic vsi_clk = 1'b0;
    logic vsi_rst_n;
    always #5 vsi_clk = ~vsi_clk;

    logic       op_valid   [3];
    logic [4:0] flags      [3];
    logic       wb_ack     [3];
    logic       op_ready   [3];
    logic       cop_idle   [3];
    logic       exec_en    [3];
    logic       beat_first [3];
    logic       beat_last  [3];
    logic       tail_en    [3];
    logic       wb_en      [3];
    logic       illegal_op [3];
    logic [4:0] op_onehot  [3];
    logic [1:0] bi0;
    logic [0:0] bi1;
    logic [2:0] bi2;

    int         nbeats   [3] = '{4, 1, 8};
    int         macc_lat [3] = '{2, 0, 2};
    int         red_lat  [3] = '{2, 2, 2};
    logic [4:0] exp_onehot [3];
    int         n_chk  = 0;
    int         n_fail = 0;

`ifdef VCOP_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_busy_cyc;
    logic [31:0] perf_retired;
`endif

    vcop_seq_ctrl #(.VLEN(128), .DP_W(32), .MACC_LAT(2), .RED_LAT(2)) u_dut0 (
        .vsi_clk(vsi_clk), .vsi_rst_n(vsi_rst_n),
        .vsi_op_valid(op_valid[0]), .vsi_op_ready(op_ready[0]), .vsi_cop_idle(cop_idle[0]),
        .is_vxor(flags[0][0]), .is_vmacc(flags[0][1]), .is_vredsum(flags[0][2]),
        .is_vslideup(flags[0][3]), .is_vrgather(flags[0][4]),
        .op_onehot(op_onehot[0]), .exec_en(exec_en[0]), .beat_idx(bi0),
        .beat_first(beat_first[0]), .beat_last(beat_last[0]), .tail_en(tail_en[0]),
        .wb_en(wb_en[0]), .wb_ack(wb_ack[0]),
`ifdef VCOP_PERF_CNT_EN
        .perf_clr(perf_clr), .perf_busy_cyc(perf_busy_cyc), .perf_retired(perf_retired),
`endif
        .illegal_op(illegal_op[0])
    );

    vcop_seq_ctrl #(.VLEN(32), .DP_W(32), .MACC_LAT(0), .RED_LAT(2)) u_dut1 (
        .vsi_clk(vsi_clk), .vsi_rst_n(vsi_rst_n),
        .vsi_op_valid(op_valid[1]), .vsi_op_ready(op_ready[1]), .vsi_cop_idle(cop_idle[1]),
        .is_vxor(flags[1][0]), .is_vmacc(flags[1][1]), .is_vredsum(flags[1][2]),
        .is_vslideup(flags[1][3]), .is_vrgather(flags[1][4]),
        .op_onehot(op_onehot[1]), .exec_en(exec_en[1]), .beat_idx(bi1),
        .beat_first(beat_first[1]), .beat_last(beat_last[1]), .tail_en(tail_en[1]),
        .wb_en(wb_en[1]), .wb_ack(wb_ack[1]),
`ifdef VCOP_PERF_CNT_EN
        .perf_clr(1'b0), .perf_busy_cyc(), .perf_retired(),
`endif
        .illegal_op(illegal_op[1])
    );

    vcop_seq_ctrl #(.VLEN(256), .DP_W(32), .MACC_LAT(2), .RED_LAT(2)) u_dut2 (
        .vsi_clk(vsi_clk), .vsi_rst_n(vsi_rst_n),
        .vsi_op_valid(op_valid[2]), .vsi_op_ready(op_ready[2]), .vsi_cop_idle(cop_idle[2]),
        .is_vxor(flags[2][0]), .is_vmacc(flags[2][1]), .is_vredsum(flags[2][2]),
        .is_vslideup(flags[2][3]), .is_vrgather(flags[2][4]),
        .op_onehot(op_onehot[2]), .exec_en(exec_en[2]), .beat_idx(bi2),
        .beat_first(beat_first[2]), .beat_last(beat_last[2]), .tail_en(tail_en[2]),
        .wb_en(wb_en[2]), .wb_ack(wb_ack[2]),
`ifdef VCOP_PERF_CNT_EN
        .perf_clr(1'b0), .perf_busy_cyc(), .perf_retired(),
`endif
        .illegal_op(illegal_op[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int get_bi(input int d);
        case (d)
            0:       return int'(bi0);
            1:       return int'(bi1);
            default: return int'(bi2);
        endcase
    endfunction

    task automatic chk_idle(input int d, input string tag);
        chk($sformatf("%s_ready%0d", tag, d), op_ready[d], 1);
        chk($sformatf("%s_idle%0d", tag, d), cop_idle[d], 1);
        chk($sformatf("%s_exec%0d", tag, d), exec_en[d], 0);
        chk($sformatf("%s_tail%0d", tag, d), tail_en[d], 0);
        chk($sformatf("%s_wb%0d", tag, d), wb_en[d], 0);
        chk($sformatf("%s_first%0d", tag, d), beat_first[d], 0);
        chk($sformatf("%s_last%0d", tag, d), beat_last[d], 0);
        chk($sformatf("%s_ill%0d", tag, d), illegal_op[d], 0);
    endtask

    // Called at a negedge with DUT d idle; returns at a negedge with DUT d idle again
    task automatic run_op(input int d, input logic [4:0] f, input int ack_dly);
        int nb;
        int l;
        int total;
        bit legal;
        bit in_ex;
        bit in_tl;
        bit in_wb;
        nb    = nbeats[d];
        legal = ($countones(f) == 1);
        l     = 0;
        if (legal && f[1]) l = macc_lat[d];
        else if (legal && f[2]) l = red_lat[d];
        op_valid[d] = 1'b1;
        flags[d]    = f;
        @(negedge vsi_clk);
        op_valid[d] = 1'b0;
        flags[d]    = 5'($urandom);
        if (!legal) begin
            chk($sformatf("ill_pulse%0d", d), illegal_op[d], 1);
            chk($sformatf("ill_ready%0d", d), op_ready[d], 1);
            chk($sformatf("ill_idle%0d", d), cop_idle[d], 1);
            chk($sformatf("ill_onehot%0d", d), op_onehot[d], exp_onehot[d]);
            @(negedge vsi_clk);
            chk($sformatf("ill_once%0d", d), illegal_op[d], 0);
            return;
        end
        exp_onehot[d] = f;
        chk($sformatf("onehot%0d", d), op_onehot[d], f);
        total = nb + l + ack_dly + 1;
        for (int c = 0; c < total; c++) begin
            in_ex = (c < nb);
            in_tl = !in_ex && (c < nb + l);
            in_wb = (c >= nb + l);
            chk($sformatf("exec%0d_c%0d", d, c), exec_en[d], in_ex);
            chk($sformatf("tail%0d_c%0d", d, c), tail_en[d], in_tl);
            chk($sformatf("wb%0d_c%0d", d, c), wb_en[d], in_wb);
            chk($sformatf("busy_ready%0d_c%0d", d, c), op_ready[d], 0);
            chk($sformatf("busy_idle%0d_c%0d", d, c), cop_idle[d], 0);
            chk($sformatf("first%0d_c%0d", d, c), beat_first[d], in_ex && (c == 0));
            chk($sformatf("last%0d_c%0d", d, c), beat_last[d], in_ex && (c == nb - 1));
            if (in_ex) chk($sformatf("beat%0d_c%0d", d, c), get_bi(d), c);
            wb_ack[d] = in_wb ? (c - nb - l == ack_dly) : 1'($urandom);
            @(negedge vsi_clk);
        end
        wb_ack[d] = 1'b0;
        chk_idle(d, "done");
    endtask

    initial begin
        vsi_rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            op_valid[d]   = 1'b0;
            flags[d]      = '0;
            wb_ack[d]     = 1'b0;
            exp_onehot[d] = '0;
        end
`ifdef VCOP_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        repeat (3) @(negedge vsi_clk);
        for (int d = 0; d < 3; d++) begin
            chk_idle(d, "rst");
            chk($sformatf("rst_onehot%0d", d), op_onehot[d], 0);
            chk($sformatf("rst_beat%0d", d), get_bi(d), 0);
        end
        vsi_rst_n = 1'b1;
        @(negedge vsi_clk);
        chk_idle(0, "post_rst");

        run_op(0, 5'b00001, 0);
        run_op(0, 5'b00100, 3);
        run_op(0, 5'b00011, 0);
        run_op(0, 5'b00000, 1);
        run_op(1, 5'b00010, 0);
        run_op(2, 5'b00001, 1);

        // Abort a vmacc in its drain tail with an asynchronous reset
        op_valid[0] = 1'b1;
        flags[0]    = 5'b00010;
        @(negedge vsi_clk);
        op_valid[0] = 1'b0;
        repeat (4) @(negedge vsi_clk);
        chk("abort_in_tail", tail_en[0], 1);
        #1 vsi_rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk_idle(d, "abort");
            chk($sformatf("abort_onehot%0d", d), op_onehot[d], 0);
            chk($sformatf("abort_beat%0d", d), get_bi(d), 0);
            exp_onehot[d] = '0;
        end
        @(negedge vsi_clk);
        vsi_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge vsi_clk);
            chk("abort_no_wb", wb_en[0], 0);
            chk("abort_stay_idle", cop_idle[0], 1);
        end

        for (int i = 0; i < 40; i++) begin
            int         d;
            logic [4:0] f;
            logic [4:0] one;
            d   = int'($urandom_range(0, 2));
            one = 5'b00001;
            f   = ($urandom_range(0, 3) != 0) ? (one << $urandom_range(0, 4)) : 5'($urandom);
            run_op(d, f, int'($urandom_range(0, 3)));
        end

`ifdef VCOP_PERF_CNT_EN
        perf_clr = 1'b1;
        @(negedge vsi_clk);
        perf_clr = 1'b0;
        chk("perf_clr_busy", perf_busy_cyc, 0);
        chk("perf_clr_ret", perf_retired, 0);
        for (int i = 0; i < 3; i++) run_op(0, 5'b00001, 0);
        chk("perf_busy", perf_busy_cyc, 15);
        chk("perf_retired", perf_retired, 3);
        perf_clr = 1'b1;
        @(negedge vsi_clk);
        perf_clr = 1'b0;
        chk("perf_clr2_busy", perf_busy_cyc, 0);
        chk("perf_clr2_ret", perf_retired, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vcop_seq_ctrl.md
Name: vcop_seq_ctrl

Overview:
- Parametrised sequencing FSM for the vector coprocessor; replaces the fixed single-cycle issue controller.
- Accepts one decoded vector op per handshake and steps the datapath through NBEATS = VLEN/DP_W execute beats.
- Adds an op-dependent pipeline-drain tail (vmacc, vredsum) and a write-back state that waits for the register-file ack.
- Flags illegal decodes.

Parameters:
- VLEN, 128, vector register length in bits; must be a multiple of DP_W.
- DP_W, 32, datapath bits processed per execute beat.
- MACC_LAT, 2, drain cycles after the last vmacc beat; 0 allowed.
- RED_LAT, 2, reduction-tree drain cycles after the last vredsum beat; 0 allowed.
- Derived localparams: NBEATS = VLEN/DP_W (must be ≥1); BEAT_W = max(1, clog2(NBEATS)); TAIL_W = max(1, clog2(max(MACC_LAT, RED_LAT)+1)).

Ports:
- vsi_clk  in  1  clock.
- vsi_rst_n  in  1  reset.
- vsi_op_valid  in  1  driver presents an op.
- vsi_op_ready  out  1  controller can accept an op.
- vsi_cop_idle  out  1  FSM in IDLE.
- is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather  in  1 each  decoded op flags, sampled at accept.
- op_onehot  out  5  latched op {vrgather,vslideup,vredsum,vmacc,vxor}.
- exec_en  out  1  datapath beat enable.
- beat_idx  out  BEAT_W  current beat, 0..NBEATS-1.
- beat_first  out  1  beat_idx==0 while exec_en.
- beat_last  out  1  beat_idx==NBEATS-1 while exec_en.
- tail_en  out  1  drain cycle in progress.
- wb_en  out  1  write-back request to the register file.
- wb_ack  in  1  register file accepted the write.
- illegal_op  out  1  one-cycle pulse on an illegal accept.

Behaviour:
- Reset:
  - vsi_rst_n is asynchronous, active-low; clock is vsi_clk.
  - State resets to IDLE.
  - op_onehot=0, beat_idx=0, tail counter=0, illegal_op=0.
  - After reset: vsi_op_ready=1, vsi_cop_idle=1; all other outputs 0.
  - Reset mid-operation aborts immediately; no wb_en is issued afterwards.
- States are IDLE, EXEC, TAIL, WB.
- IDLE:
  - vsi_op_ready=1 combinationally, only in IDLE.
  - Accept occurs on vsi_op_valid&&vsi_op_ready.
  - Legal accept = exactly one is_* flag set. Latch op_onehot, clear beat_idx, go to EXEC.
  - Illegal accept = zero or more than one flag set. Pulse illegal_op the next cycle, stay in IDLE, leave op_onehot unchanged. The op is consumed, not retried.
- EXEC:
  - exec_en=1; beat_idx increments every cycle.
  - At beat_idx==NBEATS-1:
    - vmacc with MACC_LAT>0: load tail counter with MACC_LAT, go to TAIL.
    - vredsum with RED_LAT>0: load tail counter with RED_LAT, go to TAIL.
    - Otherwise go to WB.
  - NBEATS==1: beat_first and beat_last assert together.
- TAIL:
  - tail_en=1, exec_en=0; counter decrements each cycle.
  - Go to WB when the counter reaches 1 (exactly L cycles in TAIL).
- WB:
  - wb_en=1 and held until wb_ack.
  - wb_ack sampled high: go to IDLE on the next edge.
  - wb_ack is ignored outside WB.
- Latency from the accept edge to vsi_op_ready high = NBEATS + L + W cycles.
  - L = tail length (0 for ops without a tail).
  - W = WB cycles, ≥1.
- No back-to-back issue: ready is low from EXEC through WB.
- op_onehot and beat_idx hold their values in IDLE after completion.

Optional Feature:
- Macro VCOP_PERF_CNT_EN.
- Defined: adds output perf_busy_cyc (32 bits), counting cycles with the FSM not in IDLE, and output perf_retired (32 bits), counting WB completions.
  - Both counters wrap modulo 2^32.
  - Both reset to 0.
  - perf_clr input (1 bit) clears both synchronously; clear has priority over increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package vcop_pkg holds:
  - the state enum {IDLE, EXEC, TAIL, WB};
  - op one-hot bit-position constants (OP_VXOR=0 … OP_VRGATHER=4);
  - a clog2-safe width helper function.
- Sub-module vcop_beat_cnt:
  - loadable up/down counter with terminal-count flag;
  - used twice: beat counter (up) and tail counter (down).

Test Plan:
- Reset, then vxor accepted with wb_ack tied high:
  - exec_en high 4 cycles with beat_idx 0,1,2,3;
  - beat_first on cycle 1, beat_last on cycle 4;
  - wb_en 1 cycle;
  - ready again 5 cycles after the accept edge.
- vredsum with RED_LAT=2 and wb_ack delayed 3 cycles: 4 EXEC, 2 TAIL, 4 WB cycles; wb_en held through the ack; vsi_cop_idle low throughout.
- Illegal decode:
  - is_vxor=is_vmacc=1 accepted → illegal_op pulses once, FSM stays IDLE, op_onehot unchanged;
  - all flags 0 → same response.
- vsi_rst_n asserted during TAIL of vmacc → outputs return to reset values immediately; no wb_en after release.
- Parameter sweep:
  - VLEN=32, DP_W=32, MACC_LAT=0, vmacc → single beat with first=last=1, no TAIL, direct to WB;
  - VLEN=256, DP_W=32 → beat_idx counts 0..7.
- With VCOP_PERF_CNT_EN: three vxor ops with immediate ack → perf_retired=3, perf_busy_cyc=15; perf_clr pulse → both read 0 the next cycle.
